// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: two requester ports sharing one
// result bus.
interface adder_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_sub;
  logic        req1_sub;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
  );
endinterface

// File: rtl/adder32.sv
// Team 32-bit adder; carry-out is not produced, so all users get modulo-2^32 sums.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  assign sum = a + b + {31'b0, cin};
endmodule

// File: rtl/adder_arbiter.sv
// Two-port arbiter in front of a single shared adder. Subtraction runs as
// a + ~b followed by +1 on the same adder, so it takes one extra pass.
module adder_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q, result_q;
  logic        sub_q, owner_q, prio_q;
  logic        grant, accept, ld_result;
  logic [31:0] add_a, add_b, sum;

  // prio_q names the port that wins a tie; it flips away from each accepted port.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant = RR_EN ? prio_q : 1'b0;
    end else begin
      grant = bus.req1_valid;
    end
    accept = (state_q == StIdle) && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.busy       = (state_q != StIdle);
  assign bus.rsp_data   = result_q;

  adder32 u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum)
  );

  always_comb begin
    state_d        = state_q;
    add_a          = a_q;
    add_b          = b_q;
    ld_result      = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StPass1;
      end
      StPass1: begin
        add_b     = sub_q ? ~b_q : b_q;
        ld_result = 1'b1;
        state_d   = sub_q ? StPass2 : StDone;
      end
      StPass2: begin
        add_a     = result_q;
        add_b     = 32'h1;
        ld_result = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        bus.rsp0_valid = !owner_q;
        bus.rsp1_valid = owner_q;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= grant ? bus.req1_a   : bus.req0_a;
        b_q     <= grant ? bus.req1_b   : bus.req0_b;
        sub_q   <= grant ? bus.req1_sub : bus.req0_sub;
        owner_q <= grant;
        prio_q  <= !grant;
      end
      if (ld_result) result_q <= sum;
    end
  end

endmodule
